// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Each of the N stages resolves GPS groups and registers the boundary carry; a global stall freezes the pipe.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GPS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int SW = 4 * GPS;
  localparam int N  = WIDTH / SW;

  // Handshake: a beat moves on an edge where valid & ready are both high.
  // in_ready is low exactly while a result waits unconsumed (out_valid & ~out_ready).
  logic             stall;
  logic [WIDTH-1:0] b_eff;

  assign b_eff      = b_i ^ {WIDTH{sub_i}};
  assign stall      = out_valid_o & ~out_ready_i;
  assign in_ready_o = ~stall;

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    logic [SW-1:0] a_in, b_in, s_d;
    logic          c_in, v_in, c_d;
    logic [HI-1:0] s_nx;
    logic [HI-1:0] s_q;
    logic          c_q, v_q;

    if (k == 0) begin : g_src
      assign a_in = a_i[SW-1:0];
      assign b_in = b_eff[SW-1:0];
      assign c_in = sub_i | cin_i;
      assign v_in = in_valid_i & ~stall;
      assign s_nx = s_d;
    end else begin : g_src
      assign a_in = g_stage[k-1].g_ops.a_q[SW-1:0];
      assign b_in = g_stage[k-1].g_ops.b_q[SW-1:0];
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      assign s_nx = {s_d, g_stage[k-1].s_q};
    end

    always_comb begin
      logic [3:0] p, g, c;
      logic       cg;
      s_d = '0;
      p   = '0;
      g   = '0;
      c   = '0;
      cg  = c_in;
      for (int j = 0; j < GPS; j++) begin
        p    = a_in[4*j +: 4] ^ b_in[4*j +: 4];
        g    = a_in[4*j +: 4] & b_in[4*j +: 4];
        c[0] = cg;
        c[1] = g[0] | (p[0] & cg);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cg);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cg);
        s_d[4*j +: 4] = p ^ c;
        cg = (g[3] | (p[3] & (g[2] | (p[2] & (g[1] | (p[1] & g[0])))))) | (cg & (&p));
      end
      c_d = cg;
    end

    // Data fields only load with a valid beat, so bubbles leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= c_d;
          s_q <= s_nx;
        end
      end
    end

    if (k < N - 1) begin : g_ops
      localparam int RW = WIDTH - HI;
      logic [RW-1:0] a_q, b_q, a_nx, b_nx;

      if (k == 0) begin : g_ld
        assign a_nx = a_i[WIDTH-1:HI];
        assign b_nx = b_eff[WIDTH-1:HI];
      end else begin : g_ld
        assign a_nx = g_stage[k-1].g_ops.a_q[WIDTH-LO-1:SW];
        assign b_nx = g_stage[k-1].g_ops.b_q[WIDTH-LO-1:SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall && v_in) begin
          a_q <= a_nx;
          b_q <= b_nx;
        end
      end
    end

    if (k == N - 1) begin : g_msb
      logic cm_q, cm_d;
      // Carry into the MSB recovered from its sum bit and (inverted) operand bits.
      assign cm_d = s_d[SW-1] ^ a_in[SW-1] ^ b_in[SW-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cm_q <= 1'b0;
        end else if (!stall && v_in) begin
          cm_q <= cm_d;
        end
      end
    end
  end

  assign out_valid_o = g_stage[N-1].v_q;
  assign s_o         = g_stage[N-1].s_q;
  assign cout_o      = g_stage[N-1].c_q;
  assign ovf_o       = g_stage[N-1].g_msb.cm_q ^ g_stage[N-1].c_q;

endmodule
